// File: rtl/pal_cfg_loader.sv
// rtl/pal_cfg_loader.sv - word-to-serial configuration loader for one PAL shift register
//
// Accepts SR_LEN bits as ceil(SR_LEN/WORD_W) words over a valid/ready handshake,
// most-significant word first. Each word goes out MSB first on cfg_data,
// qualified by cfg_en. Only the low FIRST_BITS bits of the first word are used,
// so the stream is exactly SR_LEN bits long.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       request a load (looked at only while idle)
//   abort       cancel a load in progress (waiting for a word or shifting)
//   word_in     configuration word
//   word_valid  word_in is valid
//   word_ready  loader accepts word_in this cycle
//   cfg_data    serial bit to the PAL CFG input (0 when cfg_en is low)
//   cfg_en      PAL shift enable
//   busy        load in progress
//   done        one-cycle pulse after the final bit
module pal_cfg_loader #(
    parameter int SR_LEN = 27,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_data,
    output logic              cfg_en,
    output logic              busy,
    output logic              done
);

    localparam int NWORDS     = (SR_LEN + WORD_W - 1) / WORD_W;
    localparam int FIRST_BITS = SR_LEN - (NWORDS - 1) * WORD_W;
    localparam int IDX_W      = $clog2(NWORDS + 1);
    localparam int BIT_W      = $clog2(WORD_W + 1);
    localparam int TOT_W      = $clog2(SR_LEN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [TOT_W-1:0]  tot_cnt;
    logic [IDX_W-1:0]  word_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tot_cnt  <= '0;
            word_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    word_idx <= '0;
                    tot_cnt  <= TOT_W'(SR_LEN);
                    if (start) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // word_ready is high throughout this state, so the
                    // handshake reduces to word_valid; abort takes priority.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (word_valid) begin
                        state <= S_SHIFT;
                        if (word_idx == '0) begin
                            // Left-justify the short first word so its top
                            // used bit sits at the serial output position.
                            shreg   <= word_in << (WORD_W - FIRST_BITS);
                            bit_cnt <= BIT_W'(FIRST_BITS);
                        end else begin
                            shreg   <= word_in;
                            bit_cnt <= BIT_W'(WORD_W);
                        end
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - BIT_W'(1);
                        tot_cnt <= tot_cnt - TOT_W'(1);
                        if (bit_cnt == BIT_W'(1)) begin
                            if (tot_cnt == TOT_W'(1)) begin
                                state <= S_FINISH;
                            end else begin
                                state    <= S_WAIT;
                                word_idx <= word_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; nothing combinational from inputs.
    assign word_ready = (state == S_WAIT);
    assign cfg_en     = (state == S_SHIFT);
    assign cfg_data   = cfg_en & shreg[WORD_W-1];
    assign busy       = (state == S_WAIT) || (state == S_SHIFT);
    assign done       = (state == S_FINISH);

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb/tb_pal_cfg_loader.sv - directed self-checking bench for pal_cfg_loader
module tb_pal_cfg_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       word_valid;
    logic [7:0] word_in;
    logic       dsel;

    logic r27, d27, e27, b27, n27;
    logic r16, d16, e16, b16, n16;
    logic word_ready, cfg_data, cfg_en, busy, done;

    int vectors;
    int miscompares;

    pal_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start & ~dsel),
        .abort      (abort),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (r27),
        .cfg_data   (d27),
        .cfg_en     (e27),
        .busy       (b27),
        .done       (n27)
    );

    pal_cfg_loader #(.SR_LEN(16), .WORD_W(8)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start & dsel),
        .abort      (abort),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (r16),
        .cfg_data   (d16),
        .cfg_en     (e16),
        .busy       (b16),
        .done       (n16)
    );

    assign word_ready = dsel ? r16 : r27;
    assign cfg_data   = dsel ? d16 : d27;
    assign cfg_en     = dsel ? e16 : e27;
    assign busy       = dsel ? b16 : b27;
    assign done       = dsel ? n16 : n27;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete load. cyc counts cycles starting with the one after the
    // START edge as 1, so the DONE cycle index equals SR_LEN + NWORDS + 1.
    task automatic do_load(input bit sel, input int nw,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3,
                           input int stall, input int abort_at, input bit poke,
                           input logic [31:0] exp_bits, input int exp_en, input int exp_done);
        logic [7:0]  w [4];
        logic [31:0] model;
        int cyc, en_cnt, done_cnt, done_at, first_en, widx, stall_left, gate_err, tail;
        bit pending;
        w = '{w0, w1, w2, w3};
        model = 0; cyc = 0; en_cnt = 0; done_cnt = 0; done_at = 0; first_en = 0;
        widx = 0; stall_left = stall; gate_err = 0; tail = -1; pending = 0;
        @(negedge clk);
        dsel  = sel;
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (pending) begin
                widx++;
                stall_left = stall;
                pending = 0;
            end
            if (cyc == 1) begin
                check("ready_after_start", word_ready, 1);
                check("busy_after_start", busy, 1);
            end
            if (!cfg_en && cfg_data) gate_err++;
            if (cfg_en) begin
                model = {model[30:0], cfg_data};
                en_cnt++;
                if (first_en == 0) first_en = cyc;
                if (poke && en_cnt == 5) start = 1'b1;
                if (en_cnt == abort_at) begin
                    abort = 1'b1;
                    tail  = cyc + 1;
                end
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
                check("busy_in_finish", busy, 0);
                if (poke) start = 1'b1;
            end
            if (cyc == tail) begin
                check("abort_en_low", cfg_en, 0);
                check("abort_busy_low", busy, 0);
            end
            if (widx < nw && stall_left == 0 && tail < 0) begin
                word_valid = 1'b1;
                word_in    = w[widx[1:0]];
            end else begin
                word_valid = 1'b0;
                if (word_ready && stall_left > 0) stall_left--;
            end
            pending = word_valid && word_ready && !abort;
            if (done_at != 0 && cyc == done_at + 1) begin
                check("idle_after_done", busy, 0);
                break;
            end
            if (tail > 0 && cyc == tail + 40) break;
            if (cyc > 400) begin
                check("timeout", 1, 0);
                break;
            end
        end
        word_valid = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("en_cycles", en_cnt, exp_en);
        check("bitstream", model, exp_bits);
        check("done_pulses", done_cnt, (exp_done != 0) ? 1 : 0);
        check("done_cycle", done_at, exp_done);
        check("first_en_cycle", first_en, 2 + stall);
        check("data_gated", gate_err, 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        word_valid = 1'b0;
        word_in = 8'h00;
        dsel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", word_ready, 0);
        check("rst_en", cfg_en, 0);
        check("rst_data", cfg_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // Reset asserted asynchronously in the middle of shifting
        @(negedge clk);
        start = 1'b1; word_valid = 1'b1; word_in = 8'h05;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_shifting", cfg_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", word_ready, 0);
        check("arst_en", cfg_en, 0);
        check("arst_data", cfg_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        word_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Clean full load, valid held high
        do_load(0, 4, 8'h05, 8'hA5, 8'h3C, 8'hFF, 0, -1, 0, 32'h05A53CFF, 27, 32);
        // Producer stalls of 5 cycles before each word
        do_load(0, 4, 8'h05, 8'hA5, 8'h3C, 8'hFF, 5, -1, 0, 32'h05A53CFF, 27, 52);
        // Abort in the 10th shift cycle
        do_load(0, 4, 8'h05, 8'hA5, 8'h3C, 8'hFF, 0, 10, 0, 32'h000002D2, 10, 0);
        // Reload after abort; first word upper bits set, START poked in SHIFT and FINISH
        do_load(0, 4, 8'hFD, 8'hA5, 8'h3C, 8'hFF, 0, -1, 1, 32'h05A53CFF, 27, 32);
        // SR_LEN=16 instance, full first word
        do_load(1, 2, 8'h81, 8'h7E, 8'h00, 8'h00, 0, -1, 0, 32'h0000817E, 16, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
